// File: rtl/cpuConfig.sv
// Shared picoMIPS configuration: datapath width and multiplier FSM states.
package cpuConfig;
  localparam int N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulState_t;
endpackage

// File: rtl/seq_fxmul.sv
// Sequential signed Q1.(N-1) x integer multiplier: one bit of b per clock,
// LSB first, with the sign bit of b subtracted on the last step.
module seq_fxmul
  import cpuConfig::*;
#(
  parameter int N = cpuConfig::N
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output mulState_t    state
);

  // Handshake: start is sampled only in IDLE; done pulses for exactly one cycle
  // and result stays valid from that cycle until the next accepted start.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mulState_t      state_next;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [2*N-1:0] term;
  logic [CW-1:0]  cnt;
  logic           last;

  assign last = (cnt == CW'(N - 1));

  // Two's complement weight of b[N-1] is negative, so the final step subtracts.
  always_comb begin
    term     = '0;
    acc_next = acc;
    if (b_q[cnt]) term = {{N{a_q[N-1]}}, a_q} << cnt;
    acc_next = last ? (acc - term) : (acc + term);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          // Drop N-1 fraction bits (floor) and keep the low N bits (wrap).
          if (last) result <= acc_next[2*N-2 -: N];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_fxmul.sv
// Directed bench for seq_fxmul: latency, floor/wrap arithmetic, ignored start,
// mid-run reset and back-to-back issue with start held high.
module tb_seq_fxmul;
  import cpuConfig::*;

  logic       clk = 1'b0;
  logic       nReset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  mulState_t  state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  seq_fxmul #(.N(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .state  (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (nReset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", {24'd0, result}, {24'd0, exp_v});
      end
    end
  end

  // One multiply; inject_at > 0 pulses a rogue start at that RUN cycle.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ev, input int inject_at);
    int lat;
    int busy_n;
    bit stable;
    logic [7:0] r0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(ev);
    @(negedge clk);
    r0 = result;
    start = 1'b0;
    a = ~av; b = ~bv;
    lat = 1; busy_n = 0; stable = 1'b1;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      if (result !== r0) stable = 1'b0;
      if (inject_at > 0 && lat == inject_at) begin
        start = 1'b1; a = 8'h7F; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_result_stable"}, {31'd0, stable}, 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  int t;
  int last_done_t;
  int n_done;
  int unstable;
  bit seen_busy;
  logic [7:0] r_hold;

  initial begin
    nReset = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_state",  {30'd0, state}, {30'd0, IDLE});
    nReset = 1'b1;

    run_op("mul_0p75x6",   8'h60, 8'h06, 8'h04, 0);
    run_op("mul_m0p5x5",   8'hC0, 8'h05, 8'hFD, 0);
    run_op("mul_m1xm128",  8'h80, 8'h80, 8'h80, 0);
    run_op("mul_maxxm1",   8'h7F, 8'hFF, 8'hFF, 0);

    // rogue start during RUN must be neither applied nor queued
    run_op("ignore_start", 8'h60, 8'h06, 8'h04, 3);
    seen_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    check("no_queued_run", {31'd0, seen_busy}, 32'd0);

    // reset in RUN cycle 4 aborts without a done pulse
    @(negedge clk);
    a = 8'hC0; b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    nReset = 1'b0;
    #1;
    check("abort_busy",   {31'd0, busy}, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_state",  {30'd0, state}, {30'd0, IDLE});
    @(negedge clk);
    nReset = 1'b1;
    run_op("post_reset", 8'hC0, 8'h05, 8'hFD, 0);

    // start held high: back-to-back runs every N+2 cycles
    repeat (3) exp_q.push_back(8'hFA);
    @(negedge clk);
    a = 8'h60; b = 8'hF9; start = 1'b1;
    r_hold = result;
    t = 0; last_done_t = 0; n_done = 0; unstable = 0;
    while (n_done < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) begin
        n_done++;
        if (n_done == 1) check("b2b_first_latency", t, 9);
        else check("b2b_interval", t - last_done_t, 10);
        last_done_t = t;
        r_hold = result;
      end else if (result !== r_hold) begin
        unstable++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", n_done, 3);
    check("b2b_result_stable", unstable, 0);

    repeat (14) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
